// File: rtl/button_debouncer_pkg.sv
// Shared constants for the button debouncer peripheral: register offsets
// (word index taken from address bits [3:2]) and the bus window base.
package button_debouncer_pkg;

  localparam logic [1:0] BTN_STATE    = 2'd0;
  localparam logic [1:0] BTN_PRESSED  = 2'd1;
  localparam logic [1:0] BTN_RELEASED = 2'd2;
  localparam logic [1:0] BTN_RESERVED = 2'd3;

  // Byte address of the 16-byte window, decoded by the SoC top level.
  localparam logic [31:0] BTN_BASE_ADDR = 32'h0001_0040;

endpackage

// File: rtl/button_debouncer_debounce_bit.sv
// One button lane: two-flop synchroniser, stability counter and the
// debounced level. rise/fall pulse on the edge where the level commits.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 36000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             stable_q;
  logic             commit;

  // The synchronised input has differed from the debounced level for the
  // whole stability window: this edge adopts the new level.
  assign commit = (s2 != stable_q) && (cnt == CNT_LAST);

  // Synchroniser, stability counter and debounced level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      cnt      <= '0;
      stable_q <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == stable_q) begin
        cnt <= '0;
      end else if (commit) begin
        stable_q <= s2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign stable = stable_q;
  assign rise   = commit & s2;
  assign fall   = commit & ~s2;

endmodule

// File: rtl/button_debouncer.sv
// Memory-mapped debounced button block: per-pin debounce lanes, sticky
// PRESSED/RELEASED flags with write-1-to-clear, and the bus read mux.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int BUTTONCOUNT     = 4,
  parameter int DEBOUNCE_CYCLES = 36000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUTTONCOUNT-1:0] buttons_in,
  input  logic [31:0]            address_in,
  input  logic                   sel_in,
  input  logic                   read_in,
  output logic [31:0]            read_value_out,
  input  logic [3:0]             write_mask_in,
  input  logic [31:0]            write_value_in,
  output logic                   ready_out,
  output logic                   event_out
);

  // Bus handshake: an access is a cycle with sel_in=1; ready_out follows
  // sel_in combinationally, so every access completes in that same cycle.
  // A write commits at the clock edge ending that cycle; reads are free of
  // side effects, so read_in needs no decoding.

  logic [BUTTONCOUNT-1:0] state_vec;
  logic [BUTTONCOUNT-1:0] rise_vec;
  logic [BUTTONCOUNT-1:0] fall_vec;
  logic [BUTTONCOUNT-1:0] pressed_q;
  logic [BUTTONCOUNT-1:0] released_q;
  logic [BUTTONCOUNT-1:0] clr_pressed;
  logic [BUTTONCOUNT-1:0] clr_released;
  logic [BUTTONCOUNT-1:0] rd_reg;
  logic                   wr_low_byte;
  logic                   unused_bus;

  for (genvar i = 0; i < BUTTONCOUNT; i++) begin : g_lane
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .pin   (buttons_in[i]),
      .stable(state_vec[i]),
      .rise  (rise_vec[i]),
      .fall  (fall_vec[i])
    );
  end

  // Only byte lane 0 carries flag bits, so only it can clear them.
  assign wr_low_byte = sel_in & write_mask_in[0];

  // Clear masks for the two sticky registers.
  always_comb begin
    clr_pressed  = '0;
    clr_released = '0;
    if (wr_low_byte && (address_in[3:2] == BTN_PRESSED)) begin
      clr_pressed = write_value_in[BUTTONCOUNT-1:0];
    end
    if (wr_low_byte && (address_in[3:2] == BTN_RELEASED)) begin
      clr_released = write_value_in[BUTTONCOUNT-1:0];
    end
  end

  // Sticky edge flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pressed_q  <= '0;
      released_q <= '0;
    end else begin
      pressed_q  <= (pressed_q & ~clr_pressed) | rise_vec;
      released_q <= (released_q & ~clr_released) | fall_vec;
    end
  end

  // Register read mux, forced to zero when the window is not selected.
  always_comb begin
    rd_reg = '0;
    if (sel_in) begin
      case (address_in[3:2])
        BTN_STATE:    rd_reg = state_vec;
        BTN_PRESSED:  rd_reg = pressed_q;
        BTN_RELEASED: rd_reg = released_q;
        BTN_RESERVED: rd_reg = '0;
        default:      rd_reg = '0;
      endcase
    end
  end

  assign read_value_out = 32'(rd_reg);
  assign ready_out      = sel_in;
  assign event_out      = (|pressed_q) | (|released_q);

  // Bus bits this block does not decode.
  assign unused_bus = ^{read_in, address_in[31:4], address_in[1:0],
                        write_mask_in[3:1], write_value_in};

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, BUTTONCOUNT=4.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_button_debouncer;

  localparam int BC = 4;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [BC-1:0] buttons_in;
  logic [31:0]   address_in;
  logic          sel_in;
  logic          read_in;
  logic [31:0]   read_value_out;
  logic [3:0]    write_mask_in;
  logic [31:0]   write_value_in;
  logic          ready_out;
  logic          event_out;

  int pass_cnt  = 0;
  int check_cnt = 0;

  button_debouncer #(
    .BUTTONCOUNT    (BC),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .buttons_in    (buttons_in),
    .address_in    (address_in),
    .sel_in        (sel_in),
    .read_in       (read_in),
    .read_value_out(read_value_out),
    .write_mask_in (write_mask_in),
    .write_value_in(write_value_in),
    .ready_out     (ready_out),
    .event_out     (event_out)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Combinational read of one register; consumes no clock edge.
  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    address_in = addr;
    sel_in     = 1'b1;
    read_in    = 1'b1;
    #1;
    check(tag, read_value_out, exp);
    sel_in  = 1'b0;
    read_in = 1'b0;
    #1;
  endtask

  // One-cycle write that commits at the next rising edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] val, input logic [3:0] mask);
    address_in     = addr;
    write_value_in = val;
    write_mask_in  = mask;
    sel_in         = 1'b1;
    tick();
    sel_in         = 1'b0;
    write_mask_in  = 4'h0;
    write_value_in = 32'h0;
  endtask

  initial begin
    reset          = 1'b1;
    buttons_in     = '0;
    address_in     = 32'h0;
    sel_in         = 1'b0;
    read_in        = 1'b0;
    write_mask_in  = 4'h0;
    write_value_in = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1. Reset state, ready_out follows sel_in.
    check("ready_idle", {31'h0, ready_out}, 32'h0);
    check("event_reset", {31'h0, event_out}, 32'h0);
    read_chk("state_reset", 32'h0, 32'h0);
    read_chk("pressed_reset", 32'h4, 32'h0);
    read_chk("released_reset", 32'h8, 32'h0);
    read_chk("reserved_reset", 32'hC, 32'h0);
    sel_in = 1'b1;
    #1;
    check("ready_sel", {31'h0, ready_out}, 32'h1);
    sel_in = 1'b0;
    #1;

    // 3. Glitches of 3 cycles high never reach the stability window.
    for (int r = 0; r < 5; r++) begin
      buttons_in[2] = 1'b1;
      tick(); tick(); tick();
      buttons_in[2] = 1'b0;
      tick(); tick();
    end
    tick(); tick(); tick();
    read_chk("glitch_state", 32'h0, 32'h0);
    read_chk("glitch_pressed", 32'h4, 32'h0);
    check("glitch_event", {31'h0, event_out}, 32'h0);

    // 2. Pin 1 rises; level commits at the sixth edge after the change.
    buttons_in[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      read_chk($sformatf("rise_wait_%0d", k), 32'h0, 32'h0);
    end
    tick();
    read_chk("rise_state", 32'h0, 32'h2);
    read_chk("rise_pressed", 32'h4, 32'h2);
    check("rise_event", {31'h0, event_out}, 32'h1);
    check("rd_unselected", read_value_out, 32'h0);
    read_chk("read_no_clear", 32'h4, 32'h2);

    // 4. Clear PRESSED, then release pin 1.
    bus_write(32'h4, 32'h2, 4'b0001);
    read_chk("w1c_pressed", 32'h4, 32'h0);
    check("w1c_event", {31'h0, event_out}, 32'h0);
    buttons_in[1] = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    read_chk("fall_wait_released", 32'h8, 32'h0);
    read_chk("fall_wait_state", 32'h0, 32'h2);
    tick();
    read_chk("fall_released", 32'h8, 32'h2);
    read_chk("fall_state", 32'h0, 32'h0);
    check("fall_event", {31'h0, event_out}, 32'h1);
    bus_write(32'h0, 32'hFFFF_FFFF, 4'hF);
    read_chk("state_ro", 32'h0, 32'h0);
    read_chk("state_wr_keeps_rel", 32'h8, 32'h2);
    bus_write(32'hC, 32'hFFFF_FFFF, 4'hF);
    read_chk("reserved_ro", 32'hC, 32'h0);
    bus_write(32'h8, 32'h2, 4'b0001);
    read_chk("w1c_released", 32'h8, 32'h0);

    // 5. Clear of PRESSED[0] on the edge it sets: set wins.
    buttons_in[0] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    read_chk("coll_pre", 32'h4, 32'h0);
    bus_write(32'h4, 32'h1, 4'b0001);
    read_chk("coll_set_wins", 32'h4, 32'h1);
    read_chk("coll_state", 32'h0, 32'h1);
    bus_write(32'h4, 32'hF, 4'b0010);
    read_chk("mask_no_clear", 32'h4, 32'h1);
    bus_write(32'h4, 32'h1, 4'b0001);
    read_chk("mask_clear", 32'h4, 32'h0);

    // 6. Reset while pin 3 is mid-count (cnt=2 after the fourth edge).
    buttons_in = 4'b1000;
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_chk("rst_state", 32'h0, 32'h0);
    read_chk("rst_pressed", 32'h4, 32'h0);
    read_chk("rst_released", 32'h8, 32'h0);
    check("rst_event", {31'h0, event_out}, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    read_chk("rst_recount", 32'h4, 32'h0);
    tick(); tick();
    read_chk("rst_pressed_pin3", 32'h4, 32'h8);
    read_chk("rst_state_pin3", 32'h0, 32'h8);
    check("rst_event_pin3", {31'h0, event_out}, 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
